// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module      : writeback_regfile
// Description : Writeback-stage result select plus integer and FP register
//               files with combinational, write-through read ports. The FP
//               file optionally supports aligned double-precision pair writes
//               when the FP_DOUBLE_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  memtoreg_W,
    input  logic [4:0]  writereg_W,
    input  logic        regwrite_W,
    input  logic        regwriteF_W,
    input  logic        fp_double_W,
    input  logic [31:0] resultAlu_W,
    input  logic [31:0] read_data_W,
    input  logic [31:0] PC_plus4_W,
    input  logic [31:0] ShiftLeft16_W,
    input  logic [31:0] resultAlu_double_W,
    input  logic [31:0] readdataMem_double_W,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic [4:0]  fa1,
    input  logic [4:0]  fa2,
    output logic [31:0] fd1,
    output logic [31:0] fd2,
    output logic [31:0] fd1_hi,
    output logic [31:0] fd2_hi,
    output logic [31:0] result_W,
    output logic        dbl_misalign
);

    localparam int unsigned C_NREGS = 32;

    logic [31:0] r_x [C_NREGS];
    logic [31:0] r_f [C_NREGS];
    logic        r_misalign;

    logic [31:0] w_hi;
    logic        w_int_we;
    logic        w_fp_lo_we;
    logic        w_fp_hi_we;
    logic [4:0]  w_fp_hi_addr;

    // Low-word and high-word result select
    always_comb begin
        result_W = resultAlu_W;
        w_hi     = 32'd0;
        case (memtoreg_W)
            2'b00: begin
                result_W = resultAlu_W;
                w_hi     = resultAlu_double_W;
            end
            2'b01: begin
                result_W = read_data_W;
                w_hi     = readdataMem_double_W;
            end
            2'b10: result_W = PC_plus4_W;
            default: result_W = ShiftLeft16_W;
        endcase
    end

    // Effective write enables; register 0 of the integer file is never written
    always_comb begin
        w_int_we     = regwrite_W && (writereg_W != 5'd0);
        w_fp_hi_addr = {writereg_W[4:1], 1'b1};
`ifdef FP_DOUBLE_EN
        w_fp_lo_we   = regwriteF_W && (!fp_double_W || !writereg_W[0]);
        w_fp_hi_we   = regwriteF_W && fp_double_W && !writereg_W[0];
`else
        w_fp_lo_we   = regwriteF_W;
        w_fp_hi_we   = 1'b0;
`endif
    end

`ifndef FP_DOUBLE_EN
    // The double-precision inputs have no function in this build
    logic w_unused_dbl;
    assign w_unused_dbl = fp_double_W ^ (^w_hi) ^ w_fp_hi_we ^ (^w_fp_hi_addr);
`endif

    // Integer register file state
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C_NREGS; i++) begin
                r_x[i] <= 32'd0;
            end
        end else if (w_int_we) begin
            r_x[writereg_W] <= result_W;
        end
    end

    // FP register file state and sticky misaligned-double flag
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C_NREGS; i++) begin
                r_f[i] <= 32'd0;
            end
            r_misalign <= 1'b0;
        end else begin
            if (w_fp_lo_we) begin
                r_f[writereg_W] <= result_W;
            end
`ifdef FP_DOUBLE_EN
            if (w_fp_hi_we) begin
                r_f[w_fp_hi_addr] <= w_hi;
            end
            if (regwriteF_W && fp_double_W && writereg_W[0]) begin
                r_misalign <= 1'b1;
            end
`endif
        end
    end

    // Integer reads with write-through bypass; index 0 is hardwired to zero
    always_comb begin
        rd1 = r_x[ra1];
        rd2 = r_x[ra2];
        if (w_int_we && (writereg_W == ra1)) rd1 = result_W;
        if (w_int_we && (writereg_W == ra2)) rd2 = result_W;
        if (ra1 == 5'd0) rd1 = 32'd0;
        if (ra2 == 5'd0) rd2 = 32'd0;
    end

    // FP low-word reads with per-word bypass of single and pair writes
    always_comb begin
        fd1 = r_f[fa1];
        fd2 = r_f[fa2];
        if (w_fp_hi_we && (w_fp_hi_addr == fa1)) fd1 = w_hi;
        if (w_fp_hi_we && (w_fp_hi_addr == fa2)) fd2 = w_hi;
        if (w_fp_lo_we && (writereg_W == fa1))   fd1 = result_W;
        if (w_fp_lo_we && (writereg_W == fa2))   fd2 = result_W;
    end

`ifdef FP_DOUBLE_EN
    logic [4:0] w_fa1_hi;
    logic [4:0] w_fa2_hi;
    assign w_fa1_hi = {fa1[4:1], 1'b1};
    assign w_fa2_hi = {fa2[4:1], 1'b1};

    // FP high-word reads (odd partner register) with per-word bypass
    always_comb begin
        fd1_hi = r_f[w_fa1_hi];
        fd2_hi = r_f[w_fa2_hi];
        if (w_fp_hi_we && (w_fp_hi_addr == w_fa1_hi)) fd1_hi = w_hi;
        if (w_fp_hi_we && (w_fp_hi_addr == w_fa2_hi)) fd2_hi = w_hi;
        if (w_fp_lo_we && (writereg_W == w_fa1_hi))   fd1_hi = result_W;
        if (w_fp_lo_we && (writereg_W == w_fa2_hi))   fd2_hi = result_W;
    end

    assign dbl_misalign = r_misalign;
`else
    // Without pair support the high-word ports and flag read as zero
    logic w_unused_misalign;
    assign w_unused_misalign = r_misalign;
    assign fd1_hi       = 32'd0;
    assign fd2_hi       = 32'd0;
    assign dbl_misalign = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_regfile
// Description : Directed self-checking bench for writeback_regfile. Pair-write
//               checks are selected by the FP_DOUBLE_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  memtoreg_W;
    logic [4:0]  writereg_W;
    logic        regwrite_W, regwriteF_W, fp_double_W;
    logic [31:0] resultAlu_W, read_data_W, PC_plus4_W, ShiftLeft16_W;
    logic [31:0] resultAlu_double_W, readdataMem_double_W;
    logic [4:0]  ra1, ra2, fa1, fa2;
    logic [31:0] rd1, rd2, fd1, fd2, fd1_hi, fd2_hi, result_W;
    logic        dbl_misalign;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk                 (clk),
        .reset               (reset),
        .memtoreg_W          (memtoreg_W),
        .writereg_W          (writereg_W),
        .regwrite_W          (regwrite_W),
        .regwriteF_W         (regwriteF_W),
        .fp_double_W         (fp_double_W),
        .resultAlu_W         (resultAlu_W),
        .read_data_W         (read_data_W),
        .PC_plus4_W          (PC_plus4_W),
        .ShiftLeft16_W       (ShiftLeft16_W),
        .resultAlu_double_W  (resultAlu_double_W),
        .readdataMem_double_W(readdataMem_double_W),
        .ra1                 (ra1),
        .ra2                 (ra2),
        .rd1                 (rd1),
        .rd2                 (rd2),
        .fa1                 (fa1),
        .fa2                 (fa2),
        .fd1                 (fd1),
        .fd2                 (fd2),
        .fd1_hi              (fd1_hi),
        .fd2_hi              (fd2_hi),
        .result_W            (result_W),
        .dbl_misalign        (dbl_misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance through one rising edge, returning 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regwrite_W  = 1'b0;
        regwriteF_W = 1'b0;
        fp_double_W = 1'b0;
    endtask

    task automatic fp_single(input logic [4:0] idx, input logic [31:0] val);
        memtoreg_W = 2'b00; resultAlu_W = val; writereg_W = idx;
        regwriteF_W = 1'b1; fp_double_W = 1'b0;
        tick();
        idle();
    endtask

    initial begin
        reset = 1'b1;
        memtoreg_W = 2'b00; writereg_W = 5'd0;
        idle();
        resultAlu_W = 32'hA1A1A1A1; read_data_W = 32'hB2B2B2B2;
        PC_plus4_W = 32'hC3C3C3C3; ShiftLeft16_W = 32'hD4D40000;
        resultAlu_double_W = 32'h0; readdataMem_double_W = 32'h0;
        ra1 = 5'd1; ra2 = 5'd2; fa1 = 5'd1; fa2 = 5'd2;
        #1;
        tick();
        tick();

        // Reset state and result select (combinational even during reset)
        check("reset_rd1", rd1, 32'h0);
        check("reset_fd1", fd1, 32'h0);
        check("reset_misalign", {31'd0, dbl_misalign}, 32'h0);
        memtoreg_W = 2'b00; #1 check("sel_alu", result_W, 32'hA1A1A1A1);
        memtoreg_W = 2'b01; #1 check("sel_mem", result_W, 32'hB2B2B2B2);
        memtoreg_W = 2'b10; #1 check("sel_pc4", result_W, 32'hC3C3C3C3);
        memtoreg_W = 2'b11; #1 check("sel_lui", result_W, 32'hD4D40000);
        reset = 1'b0;
        tick();

        // PC+4 into x31 (link register)
        memtoreg_W = 2'b10; PC_plus4_W = 32'h00400008; writereg_W = 5'd31;
        regwrite_W = 1'b1;
        tick();
        idle();
        ra1 = 5'd31; #1;
        check("x31_pc4", rd1, 32'h00400008);

        // Writes to x0 are discarded, also on the bypass path
        memtoreg_W = 2'b00; resultAlu_W = 32'hDEADBEEF; writereg_W = 5'd0;
        regwrite_W = 1'b1; ra1 = 5'd0; #1;
        check("x0_same_cycle", rd1, 32'h0);
        tick();
        idle(); #1;
        check("x0_after", rd1, 32'h0);

        // Memory result into x5 with same-cycle bypass on port 2
        memtoreg_W = 2'b01; read_data_W = 32'h00001234; writereg_W = 5'd5;
        regwrite_W = 1'b1; ra2 = 5'd5; ra1 = 5'd31; #1;
        check("x5_bypass", rd2, 32'h00001234);
        check("x31_unaffected", rd1, 32'h00400008);
        tick();
        idle(); #1;
        check("x5_after", rd2, 32'h00001234);

        // Concurrent integer and FP writes to index 6
        memtoreg_W = 2'b00; resultAlu_W = 32'hCAFEF00D; writereg_W = 5'd6;
        regwrite_W = 1'b1; regwriteF_W = 1'b1; fa2 = 5'd6; #1;
        check("f6_bypass", fd2, 32'hCAFEF00D);
        tick();
        idle();
        ra1 = 5'd6; fa1 = 5'd6; #1;
        check("x6_after", rd1, 32'hCAFEF00D);
        check("f6_after", fd1, 32'hCAFEF00D);
        fa1 = 5'd7; #1;
        check("f7_untouched", fd1, 32'h0);

        // Prefill f4, f5, f7, f8 with known patterns
        fp_single(5'd4, 32'h11111111);
        fp_single(5'd5, 32'h55555555);
        fp_single(5'd7, 32'h77777777);
        fp_single(5'd8, 32'h88888888);

        // Double write to f4/f5 (pi as a double: 0x400921FB... high word trimmed)
        memtoreg_W = 2'b00; resultAlu_W = 32'h0; resultAlu_double_W = 32'h40090000;
        writereg_W = 5'd4; regwriteF_W = 1'b1; fp_double_W = 1'b1;
        fa1 = 5'd4; fa2 = 5'd5; #1;
`ifdef FP_DOUBLE_EN
        check("dbl_bypass_lo", fd1, 32'h0);
        check("dbl_bypass_hi", fd1_hi, 32'h40090000);
        check("dbl_bypass_f5", fd2, 32'h40090000);
        tick();
        idle(); #1;
        check("dbl_f4", fd1, 32'h0);
        check("dbl_f4_hi", fd1_hi, 32'h40090000);
        check("dbl_f5", fd2, 32'h40090000);
        check("dbl_aligned_flag", {31'd0, dbl_misalign}, 32'h0);

        // Misaligned pair to f7: nothing written, sticky flag
        resultAlu_W = 32'hBAD0BAD0; resultAlu_double_W = 32'hBAD1BAD1;
        writereg_W = 5'd7; regwriteF_W = 1'b1; fp_double_W = 1'b1;
        fa1 = 5'd7; fa2 = 5'd8; #1;
        check("mis_no_bypass_f7", fd1, 32'h77777777);
        tick();
        idle(); #1;
        check("mis_f7", fd1, 32'h77777777);
        check("mis_f8", fd2, 32'h88888888);
        check("mis_flag", {31'd0, dbl_misalign}, 32'h1);
        tick();
        tick();
        check("mis_flag_sticky", {31'd0, dbl_misalign}, 32'h1);
`else
        check("nodbl_hi_zero", fd1_hi, 32'h0);
        tick();
        idle(); #1;
        check("nodbl_f4_single", fd1, 32'h0);
        check("nodbl_f5_kept", fd2, 32'h55555555);
        check("nodbl_hi_after", fd2_hi, 32'h0);
        writereg_W = 5'd7; resultAlu_W = 32'h0000BEEF;
        regwriteF_W = 1'b1; fp_double_W = 1'b1; fa1 = 5'd7;
        tick();
        idle(); #1;
        check("nodbl_f7_single", fd1, 32'h0000BEEF);
        check("nodbl_flag_zero", {31'd0, dbl_misalign}, 32'h0);
`endif

        // Reset wins over a simultaneous write
        reset = 1'b1; memtoreg_W = 2'b00; resultAlu_W = 32'h00000055;
        writereg_W = 5'd3; regwrite_W = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        ra1 = 5'd3; ra2 = 5'd31; fa1 = 5'd6; fa2 = 5'd5; #1;
        check("rst_x3_lost", rd1, 32'h0);
        check("rst_x31", rd2, 32'h0);
        check("rst_f6", fd1, 32'h0);
        check("rst_f5", fd2, 32'h0);
        check("rst_misalign", {31'd0, dbl_misalign}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL provide port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL provide port memtoreg_W, input, 2 bits: result select (00 ALU, 01 memory, 10 PC+4, 11 upper-immediate).
REQ-004 SHALL provide port writereg_W, input, 5 bits: destination register index.
REQ-005 SHALL provide ports regwrite_W and regwriteF_W, inputs, 1 bit each: integer-file and FP-file write enables.
REQ-006 SHALL provide port fp_double_W, input, 1 bit: FP write is a double-precision pair write.
REQ-007 SHALL provide ports resultAlu_W, read_data_W, PC_plus4_W and ShiftLeft16_W, inputs, 32 bits each: low-word result candidates.
REQ-008 SHALL provide ports resultAlu_double_W and readdataMem_double_W, inputs, 32 bits each: high-word candidates.
REQ-009 SHALL provide ports ra1 and ra2, inputs, 5 bits each, with rd1 and rd2, outputs, 32 bits each: integer read ports.
REQ-010 SHALL provide ports fa1 and fa2, inputs, 5 bits each, with fd1 and fd2, outputs, 32 bits each: FP read ports.
REQ-011 SHALL provide ports fd1_hi and fd2_hi, outputs, 32 bits each: FP register at index {faN[4:1],1}.
REQ-012 SHALL provide port result_W, output, 32 bits: selected low word, used for forwarding.
REQ-013 SHALL provide port dbl_misalign, output, 1 bit: sticky misaligned-double flag.

Function
REQ-014 SHALL drive result_W combinationally as resultAlu_W, read_data_W, PC_plus4_W or ShiftLeft16_W for memtoreg_W = 00, 01, 10 or 11.
REQ-015 SHALL form the high word as resultAlu_double_W (00), readdataMem_double_W (01), or 0 (10, 11).
REQ-016 SHALL hold 32x32 integer registers; register 0 reads 0 always, and writes to it are discarded.
REQ-017 SHALL write result_W to integer register writereg_W at the clock edge when regwrite_W=1.
REQ-018 SHALL write result_W to FP register writereg_W at the clock edge when regwriteF_W=1 and fp_double_W=0.
REQ-019 SHALL let integer and FP writes in the same cycle proceed independently.
REQ-020 SHALL perform reads combinationally, with write-through bypass: an address matching an enabled same-cycle write returns the value being written (integer index 0 excepted).
REQ-021 SHALL apply the bypass per word to fd1_hi and fd2_hi as well, including the high word of a pair write.

Reset
REQ-022 SHALL clear all integer and FP registers, and dbl_misalign, to 0 on a clock edge with reset=1.
REQ-023 SHALL give reset priority over any write presented at the same edge; that write is lost.
REQ-024 SHALL continue combinational outputs during reset; read outputs reflect cleared contents from the next cycle onward.

Configuration
REQ-025 With FP_DOUBLE_EN defined, regwriteF_W=1 with fp_double_W=1 and writereg_W[0]=0 SHALL write f[writereg_W] with result_W and f[writereg_W+1] with the high word in the same edge.
REQ-026 With FP_DOUBLE_EN defined, a double write with writereg_W[0]=1 SHALL write nothing and set dbl_misalign, which stays 1 until reset.
REQ-027 Without FP_DOUBLE_EN, fp_double_W SHALL be ignored (single write per REQ-018), dbl_misalign SHALL be tied to 0, and fd1_hi and fd2_hi SHALL read as 0.

Verification
REQ-028 SHALL cover: memtoreg_W=10, PC_plus4_W=0x00400008, regwrite_W=1, writereg_W=31 -> after edge rd1 (ra1=31) = 0x00400008.
REQ-029 SHALL cover: regwrite_W=1, writereg_W=0, resultAlu_W=0xDEADBEEF -> same cycle and after, rd1 (ra1=0) = 0.
REQ-030 SHALL cover: regwrite_W=1, writereg_W=5, read_data_W=0x1234, memtoreg_W=01, ra2=5 -> rd2=0x1234 in the write cycle (bypass).
REQ-031 SHALL cover, with FP_DOUBLE_EN: regwriteF_W=1, fp_double_W=1, writereg_W=4, resultAlu_W=0x0, resultAlu_double_W=0x40090000 -> fa1=4 gives fd1=0x0 and fd1_hi=0x40090000.
REQ-032 SHALL cover, with FP_DOUBLE_EN: double write to writereg_W=7 -> f7 and f8 unchanged, dbl_misalign=1 until reset.
REQ-033 SHALL cover: reset=1 with regwrite_W=1, writereg_W=3 at the same edge -> rd1 (ra1=3) = 0 afterwards.
